// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state type, latency limits and width helper for the data-memory bank
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam int MAX_RD_LAT = 4;
  localparam int MAX_WAIT_CYC = 7;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/dmem_bank_if.sv
// dmem_bank_if: valid/ready request and response channels of the data-memory bank
interface dmem_bank_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W/8-1:0] req_wstrb;
  logic [DATA_W-1:0] req_wdata;
  logic rsp_valid;
  logic rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic rsp_err;
  modport master(output req_valid, req_we, req_addr, req_wstrb, req_wdata, rsp_ready,
                 input req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave(input req_valid, req_we, req_addr, req_wstrb, req_wdata, rsp_ready,
                output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/dmem_array.sv
// dmem_array: unreset word storage with per-byte write strobes and a registered read port
module dmem_array import dmem_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 1024
) (
  input  logic clk,
  input  logic en,
  input  logic we,
  input  logic [clog2(DEPTH)-1:0] idx,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < DATA_W / 8; i++)
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end else if (en) begin
      rdata <= mem[idx];
    end
  end
endmodule

// File: rtl/dmem_bank.sv
// dmem_bank: single-port data memory with programmable latency, byte strobes, error reporting and counters
module dmem_bank import dmem_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 1024,
  parameter int RD_LAT = 1,
  parameter int WAIT_CYC = 0,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  dmem_bank_if.slave bus,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt
);
  localparam int L = RD_LAT + WAIT_CYC;
  localparam int OFF = clog2(DATA_W / 8);
  localparam int IW = clog2(DEPTH);
  localparam int CW = clog2(MAX_RD_LAT + MAX_WAIT_CYC + 1);
  if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT || WAIT_CYC < 0 || WAIT_CYC > MAX_WAIT_CYC ||
      DATA_W % 8 != 0 || DATA_W > 64) begin : g_bad
    $error("dmem_bank: illegal RD_LAT=%0d / WAIT_CYC=%0d / DATA_W=%0d", RD_LAT, WAIT_CYC, DATA_W);
  end
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic we_q, err_q, accept, hs, err_in, a_we, a_err, en;
  logic [IW-1:0] idx_q, a_idx;
  logic [DATA_W/8-1:0] wstrb_q, a_wstrb;
  logic [DATA_W-1:0] wdata_q, a_wdata, q;
  assign err_in = (bus.req_addr & ADDR_W'((1 << OFF) - 1)) != '0 || (bus.req_addr >> (OFF + IW)) != '0;
  assign accept = bus.req_valid && bus.req_ready;
  assign hs = state == RESP && bus.rsp_ready;
  always_comb begin
    nxt = accept ? (L == 1 ? RESP : BUSY) :
          (state == BUSY && cnt == CW'(1)) ? RESP :
          hs ? IDLE : state;
    // with L == 1 the access happens on the accept edge itself, so use the live request
    a_we = state == IDLE ? bus.req_we : we_q;
    a_err = state == IDLE ? err_in : err_q;
    a_idx = state == IDLE ? bus.req_addr[OFF +: IW] : idx_q;
    a_wstrb = state == IDLE ? bus.req_wstrb : wstrb_q;
    a_wdata = state == IDLE ? bus.req_wdata : wdata_q;
    en = nxt == RESP && state != RESP && !a_err;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      idx_q <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        cnt <= CW'(L - 1);
        we_q <= bus.req_we;
        err_q <= err_in;
        idx_q <= bus.req_addr[OFF +: IW];
        wstrb_q <= bus.req_wstrb;
        wdata_q <= bus.req_wdata;
      end else if (state == BUSY) begin
        cnt <= cnt - 1'b1;
      end
      if (hs && we_q && ~&wr_cnt) wr_cnt <= wr_cnt + 1'b1;
      if (hs && !we_q && ~&rd_cnt) rd_cnt <= rd_cnt + 1'b1;
    end
  end
  dmem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
    .clk(clk), .en(en), .we(a_we), .idx(a_idx), .wstrb(a_wstrb), .wdata(a_wdata), .rdata(q)
  );
  assign bus.req_ready = rst && state == IDLE;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_err = state == RESP && err_q;
  assign bus.rsp_rdata = (state == RESP && !we_q && !err_q) ? q : '0;
endmodule
